// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

    // Loader sequencing: wait for sync, read word count, stream words, flush, hold reset.
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        DRAIN,
        HOLD
    } ldr_state_e;

    // Frame start marker used when the integrator does not override it.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Bytes per instruction word; the stream is little-endian within a word.
    localparam int unsigned BYTES_PER_WORD = 4;

    // Place one received byte into its little-endian lane of a 32-bit word.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            default: res[31:24] = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// Loadable saturating down-counter; the loader reuses one instance for both
// the inter-byte timeout and the post-load reset hold interval.
module prog_loader_timer
    import prog_loader_pkg::*;
#(
    parameter int unsigned W = 20
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over counting; counting stops at zero so the flag stays asserted.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a framed image from the boot UART,
// writes it into instruction memory and holds the core in programming reset
// for the duration of the load plus a fixed hold interval.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned AW          = 12,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned HOLD_CYC    = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_data_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [3:0]    mem_be_o,
    input  logic          mem_gnt_i,
    output logic          prog_rst_no,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    // The timer must hold the larger of the two intervals it is reused for.
    localparam int unsigned MAX_CYC = (TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1) + 1;

    // Reload values are one less than the interval because the zero cycle itself counts.
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] HOLD_LOAD    = TW'(HOLD_CYC - 1);

    // Largest legal word count is the full memory capacity.
    localparam logic [32:0] MAX_WORDS = 33'd1 << AW;

    ldr_state_e    state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   asm_q, asm_d;
    logic [AW:0]   words_left_q, words_left_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          prog_rst_n_q, prog_rst_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [31:0]   asm_next;
    logic          granted;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_zero;

    assign asm_next = insert_byte(asm_q, byte_cnt_q, rx_data_i);
    assign granted  = req_q && mem_gnt_i;

    prog_loader_timer #(
        .W (TW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    // Next-state, byte assembly, write buffer and timer control.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        words_left_d = words_left_q;
        req_d        = req_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        tmr_load     = 1'b0;
        tmr_val      = TIMEOUT_LOAD;
        tmr_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
                    state_d    = COUNT;
                    err_d      = 1'b0;
                    byte_cnt_d = 2'd0;
                    tmr_load   = 1'b1;
                end
            end

            COUNT: begin
                tmr_en = 1'b1;
                if (rx_valid_i) begin
                    tmr_load   = 1'b1;
                    asm_d      = asm_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (asm_next == 32'd0) begin
                            state_d = HOLD;
                        end else if ({1'b0, asm_next} > MAX_WORDS) begin
                            err_d   = 1'b1;
                            state_d = HOLD;
                        end else begin
                            words_left_d = asm_next[AW:0];
                            addr_d       = '0;
                            state_d      = DATA;
                        end
                    end
                end else if (tmr_zero) begin
                    err_d   = 1'b1;
                    state_d = HOLD;
                end
            end

            DATA: begin
                tmr_en = 1'b1;
                if (granted) begin
                    req_d  = 1'b0;
                    addr_d = addr_q + AW'(1);
                end
                if (rx_valid_i) begin
                    tmr_load   = 1'b1;
                    asm_d      = asm_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (req_q && !mem_gnt_i) begin
                            err_d   = 1'b1;
                            req_d   = 1'b0;
                            state_d = HOLD;
                        end else begin
                            req_d        = 1'b1;
                            wdata_d      = asm_next;
                            words_left_d = words_left_q - (AW+1)'(1);
                            if (words_left_q == (AW+1)'(1)) begin
                                state_d = DRAIN;
                            end
                        end
                    end
                end else if (tmr_zero) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end

            DRAIN: begin
                if (granted) begin
                    req_d   = 1'b0;
                    addr_d  = addr_q + AW'(1);
                    state_d = HOLD;
                end else if (!req_q) begin
                    state_d = HOLD;
                end
            end

            HOLD: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if ((state_d == HOLD) && (state_q != HOLD)) begin
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
        end
    end

    // Status outputs are derived from the next state so that they register alongside it.
    always_comb begin
        prog_rst_n_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_q == HOLD) && (state_d == IDLE) && !err_q;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q   <= 2'd0;
            asm_q        <= 32'd0;
            words_left_q <= '0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            prog_rst_n_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            words_left_q <= words_left_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            prog_rst_n_q <= prog_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = 4'hF;
    assign prog_rst_no = prog_rst_n_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for the program loader.
module tb_prog_loader;

    localparam int         AW     = 12;
    localparam int         TO_CYC = 100;
    localparam int         HOLD   = 16;
    localparam logic [7:0] SYNC   = 8'hA5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rx_valid_i = 1'b0;
    logic [7:0]    rx_data_i = 8'h00;
    logic          mem_gnt_i = 1'b0;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic          prog_rst_no;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    prog_loader #(
        .AW          (AW),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CYC (TO_CYC),
        .HOLD_CYC    (HOLD)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_gnt_i   (mem_gnt_i),
        .prog_rst_no (prog_rst_no),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    wr_t         exp_q[$];
    logic [31:0] frame_words[0:15];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          wr_base = 0;
    int          done_base = 0;
    int          last_grant_cyc = 0;
    int          last_byte_cyc = 0;
    int          sync_cyc = 0;
    int          fall_cyc = 0;
    int          rise_cyc = 0;
    logic        gnt_low = 1'b0;

    // Free-running clock and cycle index.
    initial forever #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one byte after an idle gap; valid lasts one cycle unless the next call follows at once.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        repeat (gap) begin
            @(posedge clk_i);
            #1;
        end
        rx_valid_i    = 1'b1;
        rx_data_i     = b;
        last_byte_cyc = cyc;
    endtask

    task automatic idleBus();
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    // Reference model: a well-formed frame of n words writes word i at address i.
    task automatic expectWrites(input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = AW'(i);
            e.data = frame_words[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic sendFrame(input logic [31:0] n, input int nsend, input int max_gap);
        logic [31:0] w;
        done_base = done_cnt;
        wr_base   = wr_cnt;
        applyStimulus(SYNC, int'($urandom_range(0, max_gap)));
        sync_cyc = last_byte_cyc;
        for (int i = 0; i < 4; i++) begin
            w = n >> (8 * i);
            applyStimulus(w[7:0], int'($urandom_range(0, max_gap)));
        end
        for (int k = 0; k < nsend; k++) begin
            for (int i = 0; i < 4; i++) begin
                w = frame_words[k] >> (8 * i);
                applyStimulus(w[7:0], int'($urandom_range(0, max_gap)));
            end
        end
        idleBus();
    endtask

    task automatic waitIdle(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL idle_wait: busy_o still 1 after %0d cycles, required 0", budget);
        end
        repeat (2) @(negedge clk_i);
    endtask

    // Frame outcome: error flag, done pulses, write count and reset-release timing.
    task automatic checkFrame(input string tag, input bit exp_err, input int exp_done,
                              input int exp_wr, input bit from_grant, input int delay);
        int anchor;
        waitIdle(TO_CYC + HOLD + 100);
        anchor = from_grant ? last_grant_cyc : last_byte_cyc;
        checkOutput({tag, "_err"}, 64'(err_o), 64'(exp_err));
        checkOutput({tag, "_done"}, 64'(done_cnt - done_base), 64'(exp_done));
        checkOutput({tag, "_writes"}, 64'(wr_cnt - wr_base), 64'(exp_wr));
        checkOutput({tag, "_rst_fall"}, 64'(fall_cyc - sync_cyc), 64'd1);
        checkOutput({tag, "_rst_release"}, 64'(rise_cyc - anchor), 64'(delay));
        checkOutput({tag, "_prog_rst"}, 64'(prog_rst_no), 64'd1);
        exp_q.delete();
    endtask

    // Memory responder: random grants, forced after two waiting cycles, or held off on request.
    initial begin : responder
        int stall = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (gnt_low || !mem_req_o) begin
                mem_gnt_i = 1'b0;
                stall     = 0;
            end else if (stall >= 2) begin
                mem_gnt_i = 1'b1;
                stall     = 0;
            end else begin
                mem_gnt_i = ($urandom_range(0, 1) == 1);
                stall     = mem_gnt_i ? 0 : stall + 1;
            end
        end
    end

    // Monitor: pops the scoreboard on each completed write and tracks reset edges and done pulses.
    initial begin : monitor
        wr_t           e;
        logic          prev_prst = 1'b1;
        logic          prev_stall = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        logic [31:0]   prev_data = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_prst  = 1'b1;
                prev_stall = 1'b0;
            end else begin
                if (mem_req_o && mem_gnt_i) begin
                    wr_cnt++;
                    last_grant_cyc = cyc;
                    checkOutput("wr_we", 64'(mem_we_o), 64'd1);
                    checkOutput("wr_be", 64'(mem_be_o), 64'hF);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL wr_unexpected: write addr 0x%0h data 0x%0h, required no write",
                                 mem_addr_o, mem_wdata_o);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("wr_addr", 64'(mem_addr_o), 64'(e.addr));
                        checkOutput("wr_data", 64'(mem_wdata_o), 64'(e.data));
                    end
                end
                if (prev_stall && mem_req_o) begin
                    checkOutput("stall_addr", 64'(mem_addr_o), 64'(prev_addr));
                    checkOutput("stall_data", 64'(mem_wdata_o), 64'(prev_data));
                end
                if (done_o) begin
                    done_cnt++;
                    checkOutput("done_rst_high", 64'(prog_rst_no), 64'd1);
                end
                if (prev_prst && !prog_rst_no) fall_cyc = cyc;
                if (!prev_prst && prog_rst_no) rise_cyc = cyc;
                prev_prst  = prog_rst_no;
                prev_stall = mem_req_o && !mem_gnt_i;
                prev_addr  = mem_addr_o;
                prev_data  = mem_wdata_o;
            end
        end
    end

    initial begin : stimulus
        int n;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_prog_rst_no", 64'(prog_rst_no), 64'd1);
        checkOutput("rst_mem_req", 64'(mem_req_o), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we_o), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        #2 rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checkOutput("post_rst_busy", 64'(busy_o), 64'd0);

        $display("[TB] basic two-word frame");
        frame_words[0] = 32'h12345678;
        frame_words[1] = 32'hDEADBEEF;
        expectWrites(2);
        sendFrame(32'd2, 2, 2);
        checkFrame("basic", 1'b0, 1, 2, 1'b1, HOLD + 1);

        $display("[TB] junk bytes in idle then one-word frame");
        applyStimulus(8'h00, 0);
        applyStimulus(8'h11, 1);
        idleBus();
        repeat (3) @(negedge clk_i);
        checkOutput("junk_busy", 64'(busy_o), 64'd0);
        checkOutput("junk_prog_rst", 64'(prog_rst_no), 64'd1);
        checkOutput("junk_req", 64'(mem_req_o), 64'd0);
        frame_words[0] = $urandom();
        expectWrites(1);
        sendFrame(32'd1, 1, 1);
        checkFrame("single", 1'b0, 1, 1, 1'b1, HOLD + 1);

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) frame_words[i] = $urandom();
            expectWrites(n);
            sendFrame(32'(n), n, int'($urandom_range(0, 3)));
            checkFrame("rand", 1'b0, 1, n, 1'b1, HOLD + 1);
        end

        $display("[TB] write-buffer overflow");
        gnt_low = 1'b1;
        frame_words[0] = $urandom();
        frame_words[1] = $urandom();
        sendFrame(32'd2, 2, 0);
        checkFrame("overflow", 1'b1, 0, 0, 1'b0, HOLD + 1);
        gnt_low = 1'b0;

        $display("[TB] inter-byte timeout");
        for (int i = 0; i < 3; i++) frame_words[i] = $urandom();
        expectWrites(1);
        sendFrame(32'd3, 1, 1);
        checkFrame("timeout", 1'b1, 0, 1, 1'b0, TO_CYC + HOLD + 1);

        $display("[TB] zero-length frame clears previous error");
        sendFrame(32'd0, 0, 1);
        checkFrame("nzero", 1'b0, 1, 0, 1'b0, HOLD + 1);

        $display("[TB] oversized word count");
        sendFrame(32'((1 << AW) + 1), 0, 1);
        checkFrame("nbig", 1'b1, 0, 0, 1'b0, HOLD + 1);

        $display("[TB] asynchronous reset during data phase");
        gnt_low = 1'b1;
        frame_words[0] = $urandom();
        sendFrame(32'd2, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (mem_req_o) break;
        end
        checkOutput("arst_req_before", 64'(mem_req_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("arst_req", 64'(mem_req_o), 64'd0);
        checkOutput("arst_prog_rst", 64'(prog_rst_no), 64'd1);
        checkOutput("arst_busy", 64'(busy_o), 64'd0);
        checkOutput("arst_addr", 64'(mem_addr_o), 64'd0);
        checkOutput("arst_wdata", 64'(mem_wdata_o), 64'd0);
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        gnt_low = 1'b0;
        frame_words[0] = $urandom();
        expectWrites(1);
        sendFrame(32'd1, 1, 1);
        checkFrame("after_rst", 1'b0, 1, 1, 1'b1, HOLD + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
